spi_flash_bridge: RTL and testbench

//  Parametrised SPI Mode-0 flash bridge between the 6809 bus decode and the external

---
 rtl/spi_flash_pkg.sv | 60 ++++++
 rtl/spi_shift_engine.sv | 74 +++++++
 rtl/spi_flash_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_flash_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM states, request payload and frame builders for spi_flash_bridge.
// SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B + dummy byte) for bus reads.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_PROG      = 8'h02;
  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  localparam int unsigned TX_W      = 48;
  localparam int unsigned NB_W      = 6;
  localparam int unsigned WREN_BITS = 8;
  localparam int unsigned PROG_BITS = 40;
  localparam int unsigned RDSR_BITS = 16;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int unsigned RD_BITS   = 48;
`else
  localparam int unsigned RD_BITS   = 40;
`endif

  typedef logic [23:0] flash_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_FRAME,
    ST_WREN,
    ST_PROG,
    ST_RDSR,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic        rw;
    flash_addr_t addr;
    logic [7:0]  data;
  } req_t;

  // Frames are left-aligned; bits past the command/address phase shift out as 0.
  function automatic logic [TX_W-1:0] rd_frame(input flash_addr_t a);
`ifdef SPI_FLASH_FAST_READ_EN
    return {OP_FAST_READ, a, 16'h0000};
`else
    return {OP_READ, a, 16'h0000};
`endif
  endfunction

  function automatic logic [TX_W-1:0] prog_frame(input flash_addr_t a, input logic [7:0] d);
    return {OP_PROG, a, d, 8'h00};
  endfunction

  function automatic logic [TX_W-1:0] wren_frame();
    return {OP_WREN, 40'h0};
  endfunction

  function automatic logic [TX_W-1:0] rdsr_frame();
    return {OP_RDSR, 40'h0};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI Mode-0 framer: drives CS/SCK/MOSI for one N-bit frame per start and shifts MISO
// into rx_byte; done_c marks the cycle whose edge raises CS.
module spi_shift_engine
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [NB_W-1:0] nbits,
  input  logic [TX_W-1:0] tx_data,
  input  logic            spi_miso,
  output logic            done_c,
  output logic [7:0]      rx_byte,
  output logic            spi_clk,
  output logic            spi_mosi,
  output logic            spi_cs
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [NB_W-1:0]  bits_left;
  logic [TX_W-1:0]  shreg;
  logic             phase_end_c;

  assign phase_end_c = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done_c      = active && phase_end_c && spi_clk && (bits_left == NB_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active    <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_cs    <= 1'b1;
    end else if (!active) begin
      if (start) begin
        active    <= 1'b1;
        spi_cs    <= 1'b0;
        spi_clk   <= 1'b0;
        spi_mosi  <= tx_data[TX_W-1];
        shreg     <= {tx_data[TX_W-2:0], 1'b0};
        bits_left <= nbits;
        div_cnt   <= '0;
      end
    end else if (!phase_end_c) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end else begin
      div_cnt <= '0;
      if (!spi_clk) begin
        // MISO is captured on the edge that raises SCK
        spi_clk <= 1'b1;
        rx_byte <= {rx_byte[6:0], spi_miso};
      end else if (bits_left == NB_W'(1)) begin
        spi_clk  <= 1'b0;
        spi_cs   <= 1'b1;
        spi_mosi <= 1'b0;
        active   <= 1'b0;
      end else begin
        spi_clk   <= 1'b0;
        spi_mosi  <= shreg[TX_W-1];
        shreg     <= {shreg[TX_W-2:0], 1'b0};
        bits_left <= bits_left - NB_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_flash_bridge.sv
// 6809-bus to SPI Mode-0 serial flash bridge: blocking byte read, posted WREN/PROG/RDSR write.
// SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B + dummy byte) for bus reads.
module spi_flash_bridge
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned ADDR_W    = 12,
  parameter logic [23:0] ADDR_BASE = 24'h0,
  parameter int unsigned CS_GAP    = 4,
  parameter int unsigned POLL_WIP  = 1,
  parameter int unsigned POLL_MAX  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_RW,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_DataBus,
  output logic [7:0]        o_spi_data,
  output logic              o_MemoryReady,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_SPI_CLK,
  output logic              o_SPI_MOSI,
  output logic              o_SPI_CS,
  input  logic              i_SPI_MISO
);

  localparam int unsigned GAP_W  = $clog2(CS_GAP + 1);
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);

  state_t                state_q, state_d;
  state_t                gap_next_q, gap_next_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [POLL_W-1:0]     poll_cnt_q, poll_cnt_d;
  flash_addr_t           cur_addr_q, cur_addr_d;
  logic [7:0]            cur_data_q, cur_data_d;
  req_t                  pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [7:0]            data_q, data_d;

  req_t                  req_in_c;
  req_t                  launch_c;
  logic                  start_c;
  logic [NB_W-1:0]       nbits_c;
  logic [TX_W-1:0]       tx_c;
  logic                  done_c;
  logic [7:0]            rx_byte;

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk      (clk),
    .reset    (reset),
    .start    (start_c),
    .nbits    (nbits_c),
    .tx_data  (tx_c),
    .spi_miso (i_SPI_MISO),
    .done_c   (done_c),
    .rx_byte  (rx_byte),
    .spi_clk  (o_SPI_CLK),
    .spi_mosi (o_SPI_MOSI),
    .spi_cs   (o_SPI_CS)
  );

  // Bus request mapped into the flash window (24-bit wrap is intentional)
  always_comb begin
    req_in_c.rw   = i_RW;
    req_in_c.addr = ADDR_BASE + 24'(i_addr);
    req_in_c.data = i_DataBus;
    launch_c      = pend_valid_q ? pend_q : req_in_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      gap_next_q   <= ST_IDLE;
      gap_cnt_q    <= '0;
      poll_cnt_q   <= '0;
      cur_addr_q   <= '0;
      cur_data_q   <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      gap_next_q   <= gap_next_d;
      gap_cnt_q    <= gap_cnt_d;
      poll_cnt_q   <= poll_cnt_d;
      cur_addr_q   <= cur_addr_d;
      cur_data_q   <= cur_data_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      data_q       <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gap_next_d   = gap_next_q;
    gap_cnt_d    = gap_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    cur_addr_d   = cur_addr_q;
    cur_data_d   = cur_data_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    ready_d      = ready_q;
    err_d        = err_q;
    data_d       = data_q;
    start_c      = 1'b0;
    nbits_c      = '0;
    tx_c         = '0;

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q || i_req) begin
          pend_valid_d = 1'b0;
          cur_addr_d   = launch_c.addr;
          cur_data_d   = launch_c.data;
          poll_cnt_d   = '0;
          start_c      = 1'b1;
          if (launch_c.rw) begin
            state_d = ST_RD_FRAME;
            nbits_c = NB_W'(RD_BITS);
            tx_c    = rd_frame(launch_c.addr);
            ready_d = 1'b0;
          end else begin
            state_d = ST_WREN;
            nbits_c = NB_W'(WREN_BITS);
            tx_c    = wren_frame();
            ready_d = 1'b1;
          end
        end
      end
      ST_RD_FRAME: begin
        if (done_c) begin
          data_d     = rx_byte;
          ready_d    = 1'b1;
          state_d    = ST_GAP;
          gap_next_d = ST_IDLE;
        end
      end
      ST_WREN: begin
        if (done_c) begin
          state_d    = ST_GAP;
          gap_next_d = ST_PROG;
        end
      end
      ST_PROG: begin
        if (done_c) begin
          state_d    = ST_GAP;
          gap_next_d = (POLL_WIP != 0) ? ST_RDSR : ST_IDLE;
        end
      end
      ST_RDSR: begin
        if (done_c) begin
          state_d    = ST_GAP;
          gap_next_d = ST_IDLE;
          if (rx_byte[0]) begin
            if (poll_cnt_q == POLL_W'(POLL_MAX - 1)) begin
              err_d = 1'b1;
            end else begin
              poll_cnt_d = poll_cnt_q + POLL_W'(1);
              gap_next_d = ST_RDSR;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
          gap_cnt_d = '0;
          state_d   = gap_next_q;
          start_c   = (gap_next_q != ST_IDLE);
          case (gap_next_q)
            ST_PROG: begin
              nbits_c = NB_W'(PROG_BITS);
              tx_c    = prog_frame(cur_addr_q, cur_data_q);
            end
            ST_RDSR: begin
              nbits_c = NB_W'(RDSR_BITS);
              tx_c    = rdsr_frame();
            end
            default: ;
          endcase
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Requests arriving mid-sequence park in the single-entry buffer and stall the CPU
    if (i_req && (state_q != ST_IDLE || pend_valid_q)) begin
      if (pend_valid_q) begin
        err_d = 1'b1;
      end else begin
        pend_d       = req_in_c;
        pend_valid_d = 1'b1;
        ready_d      = 1'b0;
      end
    end

    busy_d = (state_d != ST_IDLE) || pend_valid_d;
  end

  assign o_spi_data    = data_q;
  assign o_MemoryReady = ready_q;
  assign o_busy        = busy_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_spi_flash_bridge.sv
// Scoreboard bench for spi_flash_bridge: expected SPI frames queued at request time,
// compared at each CS rise against a behavioural Mode-0 flash model.
`timescale 1ns/1ps
module tb_spi_flash_bridge;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned CS_GAP   = 4;
  localparam int unsigned POLL_MAX = 4;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int unsigned RD_NB = 48;
  localparam logic [7:0]  RD_OP = 8'h0B;
`else
  localparam int unsigned RD_NB = 40;
  localparam logic [7:0]  RD_OP = 8'h03;
`endif

  typedef struct {
    int unsigned nbits;
    logic [63:0] bits;
    logic        is_read;
    logic [7:0]  rdata;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic i_req = 1'b0, req_w = 1'b0, i_RW = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [7:0] i_DataBus = '0;
  logic [7:0] spi_data;
  logic ready, busy, err, sck, mosi, cs;
  logic miso = 1'b0;
  logic [7:0] w_data;
  logic w_ready, w_busy, w_err, w_sck, w_mosi, w_cs;
  logic w_miso = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  frame_t exp_q[$];

  // flash model / monitor state
  logic [7:0]  rd_data = 8'h00;
  int          wip_left = 0;
  bit          wip_stuck = 1'b0;
  logic        cs_q = 1'b1, sck_q = 1'b0;
  int          nb = 0, cs_low = 0, gap = 0, rdy_low = 0;
  bit          seen = 1'b0;
  logic [63:0] cap = '0;
  logic [7:0]  resp = '0;
  logic        w_sck_q = 1'b0, w_cs_q = 1'b1;
  int          w_nb = 0;
  logic [31:0] w_cap = '0;

  always #5 clk = ~clk;

  spi_flash_bridge #(
    .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .ADDR_BASE(24'h0), .CS_GAP(CS_GAP),
    .POLL_WIP(1), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_RW(i_RW), .i_addr(i_addr),
    .i_DataBus(i_DataBus), .o_spi_data(spi_data), .o_MemoryReady(ready), .o_busy(busy),
    .o_err(err), .o_SPI_CLK(sck), .o_SPI_MOSI(mosi), .o_SPI_CS(cs), .i_SPI_MISO(miso)
  );

  spi_flash_bridge #(
    .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .ADDR_BASE(24'hFFFF00), .CS_GAP(CS_GAP),
    .POLL_WIP(1), .POLL_MAX(POLL_MAX)
  ) dut_w (
    .clk(clk), .reset(reset), .i_req(req_w), .i_RW(i_RW), .i_addr(i_addr),
    .i_DataBus(i_DataBus), .o_spi_data(w_data), .o_MemoryReady(w_ready), .o_busy(w_busy),
    .o_err(w_err), .o_SPI_CLK(w_sck), .o_SPI_MOSI(w_mosi), .o_SPI_CS(w_cs), .i_SPI_MISO(w_miso)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash model and frame scoreboard, sampled on the inactive clock edge
  always @(negedge clk) begin
    if (!reset) begin
      cs_q = 1'b1; sck_q = 1'b0; seen = 1'b0; miso = 1'b0; nb = 0; gap = 0;
    end else begin
      if (!ready) rdy_low++;
      if (cs_q && !cs) begin
        if (seen) check_eq("cs_gap_min", 64'(gap >= int'(CS_GAP)), 64'd1);
        nb = 0; cap = '0; cs_low = 0; resp = '0; miso = 1'b0;
      end
      if (!cs_q && cs) begin
        check_eq("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          frame_t e;
          e = exp_q.pop_front();
          check_eq("frame_bits", 64'(nb), 64'(e.nbits));
          check_eq("frame_mosi", cap, e.bits);
          check_eq("cs_low_cycles", 64'(cs_low), 64'(2 * e.nbits * CLK_DIV));
          if (e.is_read) begin
            check_eq("rd_data", 64'(spi_data), 64'(e.rdata));
            check_eq("rd_ready_at_cs_rise", 64'(ready), 64'd1);
          end
        end
        seen = 1'b1;
        gap = 0;
      end
      if (cs) gap++;
      else cs_low++;
      if (!cs && sck && !sck_q) begin
        cap = {cap[62:0], mosi};
        nb++;
      end
      if (!cs && !sck && sck_q) begin
        if (nb == 8 && cap[7:0] == 8'h05) begin
          resp = (wip_stuck || wip_left > 0) ? 8'h01 : 8'h00;
          if (wip_left > 0) wip_left--;
        end
        if (nb == int'(RD_NB) - 8 && cap[RD_NB-9 -: 8] == RD_OP) resp = rd_data;
        miso = resp[7];
        resp = {resp[6:0], 1'b0};
      end
      cs_q = cs;
      sck_q = sck;
    end
  end

  // Address capture for the offset-window instance
  always @(negedge clk) begin
    if (w_cs_q && !w_cs) begin w_nb = 0; w_cap = '0; end
    if (!w_cs && w_sck && !w_sck_q && w_nb < 32) begin
      w_cap = {w_cap[30:0], w_mosi};
      w_nb++;
    end
    w_cs_q = w_cs;
    w_sck_q = w_sck;
  end

  task automatic push_read(input logic [11:0] a, input logic [7:0] d);
    frame_t e;
    e.nbits = RD_NB;
    e.bits = 64'({RD_OP, 24'(a)}) << (RD_NB - 32);
    e.is_read = 1'b1;
    e.rdata = d;
    exp_q.push_back(e);
  endtask

  task automatic push_write(input logic [11:0] a, input logic [7:0] d, input int n_rdsr);
    frame_t e;
    e.is_read = 1'b0; e.rdata = '0;
    e.nbits = 8;  e.bits = 64'h06;                       exp_q.push_back(e);
    e.nbits = 40; e.bits = 64'({8'h02, 24'(a), d});      exp_q.push_back(e);
    for (int i = 0; i < n_rdsr; i++) begin
      e.nbits = 16; e.bits = 64'h0500;                   exp_q.push_back(e);
    end
  endtask

  task automatic bus_req(input logic rw, input logic [11:0] a, input logic [7:0] d, input bit to_w);
    @(negedge clk);
    i_RW = rw; i_addr = a; i_DataBus = d;
    if (to_w) req_w = 1'b1; else i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0; req_w = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && cs && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check_eq({tag, "_finished"}, 64'(ok), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    check_eq("rst_cs", 64'(cs), 64'd1);
    check_eq("rst_sck", 64'(sck), 64'd0);
    check_eq("rst_mosi", 64'(mosi), 64'd0);
    check_eq("rst_data", 64'(spi_data), 64'd0);
    check_eq("rst_ready", 64'(ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // plain read from idle
    rd_data = 8'hA5; push_read(12'h123, 8'hA5); rdy_low = 0;
    bus_req(1'b1, 12'h123, 8'h00, 1'b0);
    wait_done("rd1", 3000);
    check_eq("rd1_ready_low", 64'(rdy_low), 64'(2 * RD_NB * CLK_DIV));
    check_eq("rd1_data", 64'(spi_data), 64'hA5);

    // posted write with three busy polls
    wip_left = 3; push_write(12'h010, 8'h5A, 4); rdy_low = 0;
    bus_req(1'b0, 12'h010, 8'h5A, 1'b0);
    wait_done("wr1", 5000);
    check_eq("wr1_ready_never_low", 64'(rdy_low), 64'd0);
    check_eq("wr1_err", 64'(err), 64'd0);

    // write then read back-to-back: read parks in pending buffer
    wip_left = 0; rd_data = 8'h77;
    push_write(12'h020, 8'h77, 1); push_read(12'h020, 8'h77); rdy_low = 0;
    bus_req(1'b0, 12'h020, 8'h77, 1'b0);
    bus_req(1'b1, 12'h020, 8'h00, 1'b0);
    wait_done("wrrd", 5000);
    check_eq("wrrd_ready_held", 64'(rdy_low > int'(2 * RD_NB * CLK_DIV)), 64'd1);
    check_eq("wrrd_data", 64'(spi_data), 64'h77);

    // address window wraps modulo 2^24
    bus_req(1'b1, 12'h200, 8'h00, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!w_busy && w_cs) begin hit = 1'b1; break; end
    end
    check_eq("wrap_finished", 64'(hit), 64'd1);
    check_eq("wrap_cmd_addr", 64'(w_cap), 64'({RD_OP, 24'h000100}));

    // WIP stuck: poll timeout sets sticky error, bridge still usable
    wip_stuck = 1'b1; push_write(12'h044, 8'h33, POLL_MAX);
    bus_req(1'b0, 12'h044, 8'h33, 1'b0);
    wait_done("tmo", 5000);
    check_eq("tmo_err", 64'(err), 64'd1);
    check_eq("tmo_busy", 64'(busy), 64'd0);
    wip_stuck = 1'b0; rd_data = 8'h3C; push_read(12'h055, 8'h3C);
    bus_req(1'b1, 12'h055, 8'h00, 1'b0);
    wait_done("tmo_rd", 3000);
    check_eq("tmo_rd_data", 64'(spi_data), 64'h3C);
    check_eq("tmo_err_sticky", 64'(err), 64'd1);

    // reset in the middle of the page-program frame
    push_write(12'h066, 8'h99, 0);
    bus_req(1'b0, 12'h066, 8'h99, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!cs && nb == 20 && cap[19:12] == 8'h02) begin hit = 1'b1; break; end
    end
    check_eq("prog_bit20_reached", 64'(hit), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("arst_cs", 64'(cs), 64'd1);
    check_eq("arst_sck", 64'(sck), 64'd0);
    check_eq("arst_mosi", 64'(mosi), 64'd0);
    check_eq("arst_ready", 64'(ready), 64'd1);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_err", 64'(err), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    rd_data = 8'hC3; push_read(12'h001, 8'hC3);
    bus_req(1'b1, 12'h001, 8'h00, 1'b0);
    wait_done("post_rst_rd", 3000);
    check_eq("post_rst_data", 64'(spi_data), 64'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
